// File: rtl/one_to_seven_demux.sv
// one_to_seven_demux
//   Routes a single valid/ready input stream to one of seven output ports.
//   Each port has a one-word holding register. Words sent with in_sel = 7 are
//   discarded, and the saturating drop_cnt counts them.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   in_valid   source offers a word this cycle
//   in_ready   a word offered this cycle would be accepted
//   in_data    offered word (DATA_W bits)
//   in_sel     destination port 0..6, 7 = discard
//   out_valid  bit i: port i holds a valid word
//   out_ready  bit i: sink i consumes port i this cycle
//   out_data   port i word on bits [i*DATA_W +: DATA_W]
//   drop_cnt   saturating count of discarded words
//   busy       any port holds a word
module one_to_seven_demux #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [2:0]            in_sel,
  output logic [6:0]            out_valid,
  input  logic [6:0]            out_ready,
  output logic [7*DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  busy
);

  localparam int         NPORT    = 7;
  localparam logic [2:0] SEL_DROP = 3'd7;

  logic [NPORT-1:0] port_hit;
  logic [NPORT-1:0] load;
  logic [NPORT-1:0] pop;
  logic             in_xfer;
  logic             drop_xfer;

  // One-hot decode of the destination. The discard code selects no port.
  always_comb begin
    port_hit = '0;
    for (int i = 0; i < NPORT; i++) begin
      port_hit[i] = (in_sel == 3'(i));
    end
  end

  // The selected port can take a word if it is empty or is being drained in
  // this same cycle. A discard never stalls. in_valid does not enter here, so
  // there is no combinational path from in_valid to in_ready.
  assign in_ready  = ~|(port_hit & out_valid & ~out_ready);

  assign in_xfer   = in_valid & in_ready;
  assign load      = port_hit & {NPORT{in_xfer}};
  assign drop_xfer = in_xfer & (in_sel == SEL_DROP);
  assign pop       = out_valid & out_ready;

  // Per-port holding register. A load wins over a pop, so a word can be
  // replaced in the same cycle it drains and each port sustains one word
  // per cycle.
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid[p]                 <= 1'b0;
        out_data[p*DATA_W +: DATA_W] <= '0;
      end else if (load[p]) begin
        out_valid[p]                 <= 1'b1;
        out_data[p*DATA_W +: DATA_W] <= in_data;
      end else if (pop[p]) begin
        // Data is left as is; only the flag drops.
        out_valid[p]                 <= 1'b0;
      end
    end
  end

  // The counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_xfer && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign busy = |out_valid;

endmodule

// File: tb/tb_one_to_seven_demux.sv
module tb_one_to_seven_demux;

  localparam int DW      = 32;
  localparam int CW      = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [2:0]      in_sel;
  logic [6:0]      out_valid;
  logic [6:0]      out_ready;
  logic [7*DW-1:0] out_data;
  logic [CW-1:0]   drop_cnt;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  one_to_seven_demux #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pd(input int i);
    return out_data[i*DW +: DW];
  endfunction

  // Reference model: each port is a queue holding at most one word, plus the
  // last word ever written there (retained data). The drop counter is an int.
  logic [DW-1:0]   mq[7][$];
  logic [DW-1:0]   mlast[7];
  int              mdrops;
  logic [6:0]      exp_valid;
  logic [7*DW-1:0] exp_data;
  logic            exp_ready;

  initial begin
    for (int i = 0; i < 7; i++) mlast[i] = '0;
    mdrops = 0;
  end

  // Compare on the falling edge, then advance the model to what the next
  // rising edge must produce.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) begin
        mq[i].delete();
        mlast[i] = '0;
      end
      mdrops = 0;
    end
    for (int i = 0; i < 7; i++) begin
      exp_valid[i] = (mq[i].size() != 0);
      exp_data[i*DW +: DW] = mlast[i];
    end
    if (in_sel == 3'd7) exp_ready = 1'b1;
    else exp_ready = (mq[in_sel].size() == 0) || out_ready[in_sel];

    chk("m_in_ready", in_ready, exp_ready);
    chk("m_out_valid", out_valid, exp_valid);
    chk("m_out_data", out_data, exp_data);
    chk("m_drop_cnt", drop_cnt, mdrops);
    chk("m_busy", busy, exp_valid != 0);

    if (rst_n) begin
      for (int i = 0; i < 7; i++) begin
        if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
        if (in_valid && exp_ready && in_sel == i) begin
          mq[i].push_back(in_data);
          mlast[i] = in_data;
        end
      end
      if (in_valid && in_sel == 3'd7 && mdrops < CNT_MAX) mdrops++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_all();
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_sel   = 3'(i);
      in_data  = 32'h10 + i;
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    in_data   = '0;
    out_ready = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 7'd0);
    chk("rst_data", out_data, '0);
    chk("rst_drop", drop_cnt, 16'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    repeat (2) step();
    rst_n = 1'b1;

    // First word to port 3, then a second word stalls until port 3 drains.
    in_valid = 1'b1; in_sel = 3'd3; in_data = 32'hDEADBEEF;
    step();
    in_data = 32'h12345678;
    #1;
    chk("p3_valid", out_valid, 7'b0001000);
    chk("p3_data", pd(3), 32'hDEADBEEF);
    chk("p3_busy", busy, 1'b1);
    chk("p3_stall", in_ready, 1'b0);
    step();
    chk("p3_hold", pd(3), 32'hDEADBEEF);
    chk("p3_stall2", in_ready, 1'b0);
    out_ready = 7'h08;
    #1;
    chk("p3_unstall", in_ready, 1'b1);
    step();
    in_valid = 1'b0; out_ready = '0;
    #1;
    chk("p3_second", pd(3), 32'h12345678);
    chk("p3_valid2", out_valid, 7'b0001000);
    out_ready = 7'h08;
    step();
    out_ready = '0;

    // Port 5 replaced in the same cycle it drains, then a 10-word stream.
    in_valid = 1'b1; in_sel = 3'd5; in_data = 32'hAA;
    step();
    in_data = 32'h55; out_ready = 7'h20;
    #1;
    chk("p5_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; out_ready = '0;
    #1;
    chk("p5_valid", out_valid[5], 1'b1);
    chk("p5_data", pd(5), 32'h55);
    out_ready = 7'h20; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 32'h100 + k;
      #1;
      chk("stream_ready", in_ready, 1'b1);
      step();
      chk("stream_data", pd(5), 32'h100 + k);
    end
    in_valid = 1'b0;
    step();
    out_ready = '0;
    #1;
    chk("stream_drained", out_valid, 7'd0);

    // All ports full, then drained in a single cycle.
    fill_all();
    #1;
    chk("fill_valid", out_valid, 7'h7F);
    out_ready = 7'h7F;
    step();
    out_ready = '0;
    #1;
    chk("drain_valid", out_valid, 7'd0);
    chk("drain_busy", busy, 1'b0);

    // Discards while every port is full and stalled.
    fill_all();
    in_valid = 1'b1; in_sel = 3'd7;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'hBAD0 + k;
      #1;
      chk("drop_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    chk("drop_cnt3", drop_cnt, 16'd3);
    chk("drop_valid", out_valid, 7'h7F);
    for (int i = 0; i < 7; i++) chk("drop_keep", pd(i), 32'h10 + i);

    // Asynchronous reset between edges.
    out_ready = 7'h7F;
    step();
    out_ready = '0;
    in_valid = 1'b1;
    in_sel = 3'd1; in_data = 32'hA1; step();
    in_sel = 3'd4; in_data = 32'hA4; step();
    in_sel = 3'd7; step(); step();
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", out_valid, 7'b0010010);
    chk("pre_rst_drop", drop_cnt, 16'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 7'd0);
    chk("async_data", out_data, '0);
    chk("async_drop", drop_cnt, 16'd0);
    chk("async_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", out_valid, 7'd0);

    // Random traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = $urandom;
      out_ready = 7'($urandom_range(0, 127));
      step();
    end

    // Drop counter saturation.
    out_ready = 7'h7F; in_valid = 1'b1; in_sel = 3'd7;
    repeat (CNT_MAX + 2) step();
    in_valid = 1'b0;
    chk("sat_drop", drop_cnt, 16'hFFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sat_hold", drop_cnt, 16'hFFFF);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
